// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
// Sink-side checker for the VGA pixel interface. It recovers the pixel
// coordinates from hsync/vsync alone, checks the line and frame timing,
// locks once the timing has been clean for LOCK_FRAMES frames, and produces
// a per-frame additive checksum of the active pixels.
// Optional build macro: VGA_MON_BLANK_CHECK_EN. When it is defined, nonzero
// RGB outside the active area is treated as a timing violation and the
// sticky blank_err output is added.
module vga_timing_monitor #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        timing_err,
    output logic [7:0]  err_cnt
`ifdef VGA_MON_BLANK_CHECK_EN
    ,
    output logic        blank_err
`endif
);

    localparam logic [9:0] H_ACT_LO  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_HI  = 10'(H_SYNC + H_BP + H_DISPLAY);
    localparam logic [9:0] V_ACT_LO  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_HI  = 10'(V_SYNC + V_BP + V_DISPLAY);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [7:0] GOOD_LAST = 8'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Index counters stick at their maximum instead of wrapping, so a missing
    // sync edge can never alias back into a legal-looking position.
    function automatic logic [9:0] sat_inc10(input logic [9:0] value);
        return (value == 10'h3FF) ? value : value + 10'd1;
    endfunction

    logic        hs_prev_r;
    logic        vs_line_r;
    logic        h_seen_r;
    logic [9:0]  h_idx_r;
    logic [9:0]  v_idx_r;
    state_t      state_r;
    logic [7:0]  good_r;
    logic [15:0] acc_r;
    logic        pixel_valid_r;
    logic [9:0]  pixel_x_r;
    logic [9:0]  pixel_y_r;
    logic        locked_r;
    logic        frame_done_r;
    logic [15:0] frame_sum_r;
    logic        timing_err_r;
    logic [7:0]  err_cnt_r;
    logic        blank_err_r;

    logic        h_fall_s;
    logic        h_rise_s;
    logic        frame_start_s;
    logic        v_rise_s;
    logic [9:0]  h_next_s;
    logic [9:0]  v_next_s;
    logic        active_s;
    logic [15:0] pix_s;
    logic [15:0] acc_sum_s;
    logic        blank_viol_s;
    logic        any_err_s;
    logic        gate_s;
    state_t      state_next_s;
    logic [7:0]  good_next_s;

    // Decode sync edges, next coordinates, active area and every timing check.
    always_comb begin
        h_fall_s      = hs_prev_r & ~hsync;
        h_rise_s      = ~hs_prev_r & hsync;
        frame_start_s = h_fall_s & ~vsync & vs_line_r;
        v_rise_s      = h_fall_s & vsync & ~vs_line_r;
        if (h_fall_s) begin
            h_next_s = 10'd0;
        end else begin
            h_next_s = sat_inc10(h_idx_r);
        end
        if (frame_start_s) begin
            v_next_s = 10'd0;
        end else if (h_fall_s) begin
            v_next_s = sat_inc10(v_idx_r);
        end else begin
            v_next_s = v_idx_r;
        end
        active_s  = (h_next_s >= H_ACT_LO) && (h_next_s < H_ACT_HI) &&
                    (v_next_s >= V_ACT_LO) && (v_next_s < V_ACT_HI);
        pix_s     = {4'd0, blue, green, red};
        acc_sum_s = active_s ? (acc_r + pix_s) : acc_r;
        gate_s    = (state_r != ST_UNLOCKED);
`ifdef VGA_MON_BLANK_CHECK_EN
        blank_viol_s = ~active_s & (|{blue, green, red});
`else
        blank_viol_s = 1'b0;
`endif
        // Horizontal checks need one real line start after reset before
        // h_idx means anything; the frame-length check is skipped while unlocked.
        any_err_s = (h_rise_s & h_seen_r & (h_next_s != H_SYNC_W)) |
                    (h_fall_s & h_seen_r & (h_idx_r != H_LAST)) |
                    (v_rise_s & (v_next_s != V_SYNC_W)) |
                    (frame_start_s & gate_s & (v_idx_r != V_LAST)) |
                    blank_viol_s;
    end

    // Lock FSM next-state: errors always drop to UNLOCKED, clean frame starts advance.
    always_comb begin
        state_next_s = state_r;
        good_next_s  = good_r;
        case (state_r)
            ST_UNLOCKED: begin
                if (any_err_s) begin
                    state_next_s = ST_UNLOCKED;
                end else if (frame_start_s) begin
                    state_next_s = ST_ACQUIRE;
                    good_next_s  = 8'd0;
                end else begin
                    state_next_s = ST_UNLOCKED;
                end
            end
            ST_ACQUIRE: begin
                if (any_err_s) begin
                    state_next_s = ST_UNLOCKED;
                end else if (frame_start_s) begin
                    if (good_r >= GOOD_LAST) begin
                        state_next_s = ST_LOCKED;
                        good_next_s  = 8'd0;
                    end else begin
                        good_next_s  = good_r + 8'd1;
                    end
                end else begin
                    state_next_s = ST_ACQUIRE;
                end
            end
            ST_LOCKED: begin
                if (any_err_s) begin
                    state_next_s = ST_UNLOCKED;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: begin
                state_next_s = ST_UNLOCKED;
                good_next_s  = 8'd0;
            end
        endcase
    end

    // Track sync levels and recover the horizontal/vertical indices.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hs_prev_r <= 1'b1;
            vs_line_r <= 1'b1;
            h_seen_r  <= 1'b0;
            h_idx_r   <= 10'd0;
            v_idx_r   <= 10'd0;
        end else if (pix_en) begin
            hs_prev_r <= hsync;
            h_idx_r   <= h_next_s;
            v_idx_r   <= v_next_s;
            if (h_fall_s) begin
                vs_line_r <= vsync;
                h_seen_r  <= 1'b1;
            end else begin
                vs_line_r <= vs_line_r;
                h_seen_r  <= h_seen_r;
            end
        end else begin
            hs_prev_r <= hs_prev_r;
        end
    end

    // Lock FSM state register plus the registered locked flag.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r  <= ST_UNLOCKED;
            good_r   <= 8'd0;
            locked_r <= 1'b0;
        end else if (pix_en) begin
            state_r  <= state_next_s;
            good_r   <= good_next_s;
            locked_r <= (state_next_s == ST_LOCKED);
        end else begin
            state_r  <= state_r;
        end
    end

    // Accumulate active pixels and publish the sum at each clean frame start.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc_r        <= 16'd0;
            frame_sum_r  <= 16'd0;
            frame_done_r <= 1'b0;
        end else if (pix_en) begin
            frame_done_r <= frame_start_s & gate_s & ~any_err_s;
            if (any_err_s) begin
                acc_r <= 16'd0;
            end else if (frame_start_s) begin
                acc_r <= 16'd0;
                if (gate_s) begin
                    frame_sum_r <= acc_sum_s;
                end else begin
                    frame_sum_r <= frame_sum_r;
                end
            end else begin
                acc_r <= acc_sum_s;
            end
        end else begin
            frame_done_r <= 1'b0;
        end
    end

    // Register the recovered pixel coordinates for active samples.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pixel_valid_r <= 1'b0;
            pixel_x_r     <= 10'd0;
            pixel_y_r     <= 10'd0;
        end else if (pix_en) begin
            pixel_valid_r <= active_s & gate_s;
            if (active_s & gate_s) begin
                pixel_x_r <= h_next_s - H_ACT_LO;
                pixel_y_r <= v_next_s - V_ACT_LO;
            end else begin
                pixel_x_r <= 10'd0;
                pixel_y_r <= 10'd0;
            end
        end else begin
            pixel_valid_r <= pixel_valid_r;
        end
    end

    // Error pulse, saturating error counter and sticky blanking flag.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            timing_err_r <= 1'b0;
            err_cnt_r    <= 8'd0;
            blank_err_r  <= 1'b0;
        end else if (pix_en) begin
            timing_err_r <= any_err_s;
            blank_err_r  <= blank_err_r | blank_viol_s;
            if (any_err_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end else begin
            timing_err_r <= 1'b0;
        end
    end

    assign pixel_valid = pixel_valid_r;
    assign pixel_x     = pixel_x_r;
    assign pixel_y     = pixel_y_r;
    assign locked      = locked_r;
    assign frame_done  = frame_done_r;
    assign frame_sum   = frame_sum_r;
    assign timing_err  = timing_err_r;
    assign err_cnt     = err_cnt_r;
`ifdef VGA_MON_BLANK_CHECK_EN
    assign blank_err   = blank_err_r;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a scaled-down raster
// (16x10 total, 8x4 active) so many frames fit in a short run.
module tb_vga_timing_monitor;

    localparam int HD = 8;
    localparam int HS = 4;
    localparam int HBP = 2;
    localparam int HT = 16;
    localparam int VD = 4;
    localparam int VS = 2;
    localparam int VBP = 2;
    localparam int VT = 10;
    localparam int HA = HS + HBP;
    localparam int VA = VS + VBP;

    logic        clk;
    logic        clr;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        pixel_valid;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        locked;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic        timing_err;
    logic [7:0]  err_cnt;
`ifdef VGA_MON_BLANK_CHECK_EN
    logic        blank_err;
`endif

    int          n_cmp;
    int          n_bad;
    int          fd_cnt;
    int          te_cnt;
    int          fd0;
    int          te0;
    logic [15:0] sums [0:63];
    bit          pv_seen;
    logic [9:0]  first_x;
    logic [9:0]  first_y;

    vga_timing_monitor #(
        .H_DISPLAY  (HD),
        .H_SYNC     (HS),
        .H_BP       (HBP),
        .H_TOTAL    (HT),
        .V_DISPLAY  (VD),
        .V_SYNC     (VS),
        .V_BP       (VBP),
        .V_TOTAL    (VT),
        .LOCK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .pix_en     (pix_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .pixel_valid(pixel_valid),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .locked     (locked),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .timing_err (timing_err),
        .err_cnt    (err_cnt)
`ifdef VGA_MON_BLANK_CHECK_EN
        ,
        .blank_err  (blank_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One pixel sample; with gap set, an idle pix_en=0 clock follows it.
    task automatic step(input logic hs, input logic vs, input logic [11:0] rgb, input bit gap);
        hsync  = hs;
        vsync  = vs;
        {blue, green, red} = rgb;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        if (gap) begin
            pix_en = 1'b0;
            @(posedge clk);
            #1;
            pix_en = 1'b1;
        end
    endtask

    // mode 0: red = column[3:0]; mode 1: constant 12'h0F8; mode 2: black.
    task automatic run_frame(input int first_line, input int n_lines, input int vs_lines,
                             input int bad_line, input int bad_len, input int bad_hsw,
                             input int mode, input bit gap, input bit blank_dot);
        for (int l = first_line; l < n_lines; l++) begin
            int   len;
            int   hsw;
            logic vs;
            len = (l == bad_line) ? bad_len : HT;
            hsw = (l == bad_line) ? bad_hsw : HS;
            vs  = (l < vs_lines) ? 1'b0 : 1'b1;
            for (int i = 0; i < len; i++) begin
                logic [11:0] rgb;
                bit          act;
                act = (i >= HA) && (i < HA + HD) && (l >= VA) && (l < VA + VD);
                rgb = 12'h000;
                if (act && mode == 0) begin
                    rgb = {8'h00, 4'(i - HA)};
                end else if (act && mode == 1) begin
                    rgb = 12'h0F8;
                end
                if (blank_dot && l == 1 && i == 0) begin
                    rgb = 12'h001;
                end
                step((i < hsw) ? 1'b0 : 1'b1, vs, rgb, gap);
            end
        end
    endtask

    task automatic good_frame(input int mode, input bit gap);
        run_frame(0, VT, VS, -1, HT, HS, mode, gap, 1'b0);
    endtask

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (clr) begin
                if (frame_done) begin
                    if (fd_cnt < 64) begin
                        sums[fd_cnt] = frame_sum;
                    end
                    fd_cnt++;
                end
                if (timing_err) begin
                    te_cnt++;
                    check_eq("lock_drop", 32'(locked), 32'd0);
                end
                if (pixel_valid && !pv_seen) begin
                    pv_seen = 1'b1;
                    first_x = pixel_x;
                    first_y = pixel_y;
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; fd_cnt = 0; te_cnt = 0; pv_seen = 1'b0;
        first_x = 10'h3FF; first_y = 10'h3FF;
        clr = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
        red = 4'h0; green = 4'h0; blue = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(pixel_valid), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        check_eq("rst_sum", 32'(frame_sum), 32'd0);
        check_eq("rst_terr", 32'(timing_err), 32'd0);
        check_eq("rst_errcnt", 32'(err_cnt), 32'd0);
        clr = 1'b1;
        @(posedge clk);
        #1;

        // Acquire and lock on nominal timing; frame 2 uses pix_en gaps.
        good_frame(0, 1'b0);
        check_eq("f1_fd", 32'(fd_cnt), 32'd0);
        check_eq("f1_locked", 32'(locked), 32'd0);
        good_frame(0, 1'b1);
        check_eq("f2_fd", 32'(fd_cnt), 32'd1);
        check_eq("f2_locked", 32'(locked), 32'd0);
        check_eq("f1_sum", 32'(sums[0]), 32'h0070);
        good_frame(0, 1'b0);
        check_eq("f3_locked", 32'(locked), 32'd1);
        check_eq("f3_fd", 32'(fd_cnt), 32'd2);
        check_eq("f2_sum_gap", 32'(sums[1]), 32'h0070);
        check_eq("first_pv", 32'(pv_seen), 32'd1);
        check_eq("first_x", 32'(first_x), 32'd0);
        check_eq("first_y", 32'(first_y), 32'd0);
        check_eq("nominal_err", 32'(err_cnt), 32'd0);

        // Constant colour over three frames: 32 pixels * 0x0F8 = 0x1F00.
        good_frame(1, 1'b0);
        good_frame(1, 1'b0);
        good_frame(1, 1'b0);
        good_frame(0, 1'b0);
        check_eq("f3_sum", 32'(sums[2]), 32'h0070);
        check_eq("const_sum_a", 32'(sums[3]), 32'h1F00);
        check_eq("const_sum_b", 32'(sums[4]), 32'h1F00);
        check_eq("const_sum_c", 32'(sums[5]), 32'h1F00);
        check_eq("const_sum_reg", 32'(frame_sum), 32'h1F00);
        check_eq("f7_locked", 32'(locked), 32'd1);

        // Short line while locked, then relock after two clean frames.
        run_frame(0, VT, VS, 5, HT - 1, HS, 0, 1'b0, 1'b0);
        check_eq("short_errcnt", 32'(err_cnt), 32'd1);
        check_eq("short_pulses", 32'(te_cnt), 32'd1);
        check_eq("short_unlock", 32'(locked), 32'd0);
        good_frame(0, 1'b0);
        good_frame(0, 1'b0);
        check_eq("relock_early", 32'(locked), 32'd0);
        good_frame(0, 1'b0);
        check_eq("relock", 32'(locked), 32'd1);
        check_eq("relock_err", 32'(err_cnt), 32'd1);

        // Long frame: its frame start errors and must not raise frame_done.
        run_frame(0, VT + 1, VS, -1, HT, HS, 0, 1'b0, 1'b0);
        fd0 = fd_cnt;
        run_frame(0, VT, VS, 3, HT, HS - 1, 0, 1'b0, 1'b0);
        check_eq("frame_len_hsw_err", 32'(err_cnt), 32'd3);
        check_eq("err_wins_fd", 32'(fd_cnt), 32'(fd0));
        check_eq("hsw_unlocked", 32'(locked), 32'd0);
        run_frame(0, VT, VS + 1, -1, HT, HS, 0, 1'b0, 1'b0);
        check_eq("vsw_err", 32'(err_cnt), 32'd4);
        check_eq("vsw_pulses", 32'(te_cnt), 32'd4);

        // Asynchronous reset in the middle of a frame.
        run_frame(0, 5, VS, -1, HT, HS, 0, 1'b0, 1'b0);
        clr = 1'b0;
        #1;
        check_eq("mid_rst_errcnt", 32'(err_cnt), 32'd0);
        check_eq("mid_rst_locked", 32'(locked), 32'd0);
        check_eq("mid_rst_sum", 32'(frame_sum), 32'd0);
        check_eq("mid_rst_valid", 32'(pixel_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        fd0 = fd_cnt;
        te0 = te_cnt;
        run_frame(5, VT, VS, -1, HT, HS, 2, 1'b0, 1'b0);
        good_frame(0, 1'b0);
        check_eq("post_rst_nofd", 32'(fd_cnt), 32'(fd0));
        good_frame(0, 1'b0);
        check_eq("post_rst_fd", 32'(fd_cnt), 32'(fd0 + 1));
        check_eq("post_rst_sum", 32'(sums[fd0]), 32'h0070);
        check_eq("post_rst_unlocked", 32'(locked), 32'd0);
        good_frame(0, 1'b0);
        check_eq("post_rst_locked", 32'(locked), 32'd1);
        check_eq("post_rst_errcnt", 32'(err_cnt), 32'd0);
        check_eq("post_rst_pulses", 32'(te_cnt), 32'(te0));

        // Nonzero red at h_idx=0 inside blanking.
        run_frame(0, VT, VS, -1, HT, HS, 0, 1'b0, 1'b1);
`ifdef VGA_MON_BLANK_CHECK_EN
        check_eq("blank_errcnt", 32'(err_cnt), 32'd1);
        check_eq("blank_flag", 32'(blank_err), 32'd1);
        check_eq("blank_unlock", 32'(locked), 32'd0);
`else
        check_eq("blank_ignored_err", 32'(err_cnt), 32'd0);
        check_eq("blank_ignored_lock", 32'(locked), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
